icache_controller: RTL and testbench

//  Sequences the instruction cache (I_SRAM) and the instruction memory port for the fetch stage.
//  - Hits return the instruction combinationally.
//  - Misses stall fetch, read one block from imem, write it into I_SRAM, then replay the lookup.
//  - Sits between pipeline fetch and I_SRAM/imem, as the read-only peer of dcache_controller.

---
 rtl/icache_controller_pkg.sv | 23 ++
 rtl/icache_stream_buffer.sv | 54 +++++
 rtl/icache_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_icache_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_controller_pkg.sv
// icache_controller_pkg: shared types and defaults for the instruction cache controller.
//   - Default geometry (address width, instruction width, block size, imem block width).
//   - FSM state type; StPfWait exists only when ICACHE_PREFETCH_EN is defined.
//   - ic_off_w(): byte-offset width of a cache block.
package icache_controller_pkg;

  localparam int unsigned IcAddrW      = 32;
  localparam int unsigned IcWordBits   = 32;
  localparam int unsigned IcBlockWords = 4;
  localparam int unsigned IcMemBlkW    = 10;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StMissReq, StFill, StPfWait} ic_state_e;
`else
  typedef enum logic [1:0] {StIdle, StMissReq, StFill} ic_state_e;
`endif

  function automatic int unsigned ic_off_w(input int unsigned block_words,
                                           input int unsigned word_bits);
    return $clog2(block_words * word_bits / 8);
  endfunction

endpackage

// File: rtl/icache_stream_buffer.sv
// icache_stream_buffer: one-block next-line prefetch buffer (valid, tag, data).
//   clk_i, rst_i    clock, asynchronous active-high reset (clears valid, tag and data)
//   wr_en_i         write tag/data and set valid
//   wr_tag_i        imem block address of the written block
//   wr_data_i       block data
//   lookup_tag_i    imem block address being looked up
//   match_o         buffer valid and tag equal to lookup_tag_i
//   data_o          buffered block
// Only instantiated when ICACHE_PREFETCH_EN is defined.
module icache_stream_buffer #(
  parameter int unsigned TagW  = 10,
  parameter int unsigned DataW = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [TagW-1:0]  wr_tag_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic [TagW-1:0]  lookup_tag_i,
  output logic             match_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [TagW-1:0]  tag_q, tag_d;
  logic [DataW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      tag_d   = wr_tag_i;
      data_d  = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign match_o = valid_q && (tag_q == lookup_tag_i);
  assign data_o  = data_q;

endmodule

// File: rtl/icache_controller.sv
// icache_controller: sequences I_SRAM lookups and imem block reads for the fetch stage.
//   clock, reset        clock, asynchronous active-high reset (all outputs forced 0 while held)
//   fetch_ren, pc       fetch request and word-aligned byte address
//   instr, icache_stall instruction (valid on hit) and fetch hold
//   cacheRen, cacheMemWen, cacheBlockAddr, cacheDin   I_SRAM lookup / fill side
//   cacheHit, cacheDout                               I_SRAM combinational response
//   imem_ren, imem_block_address                      imem block read request
//   imem_dout, imem_ready                             imem block data, one-cycle completion pulse
// Hits return in the same cycle; a miss reads the block from imem, fills I_SRAM for one
// cycle, then returns to IDLE where the lookup is replayed.
// Optional feature macro: ICACHE_PREFETCH_EN (next-line stream buffer, adds StPfWait).
module icache_controller
  import icache_controller_pkg::*;
#(
  parameter int unsigned ADDR_W      = IcAddrW,
  parameter int unsigned WORD_BITS   = IcWordBits,
  parameter int unsigned BLOCK_WORDS = IcBlockWords,
  parameter int unsigned MEM_BLK_W   = IcMemBlkW,
  localparam int unsigned OFF_W      = ic_off_w(BLOCK_WORDS, WORD_BITS),
  localparam int unsigned BLK_BITS   = BLOCK_WORDS * WORD_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_ren,
  input  logic [ADDR_W-1:0]       pc,
  output logic [WORD_BITS-1:0]    instr,
  output logic                    icache_stall,
  output logic                    cacheRen,
  output logic                    cacheMemWen,
  output logic [ADDR_W-OFF_W-1:0] cacheBlockAddr,
  output logic [BLK_BITS-1:0]     cacheDin,
  input  logic                    cacheHit,
  input  logic [BLK_BITS-1:0]     cacheDout,
  output logic                    imem_ren,
  output logic [MEM_BLK_W-1:0]    imem_block_address,
  input  logic [BLK_BITS-1:0]     imem_dout,
  input  logic                    imem_ready
);

  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned WSEL_W = $clog2(BLOCK_WORDS);

  ic_state_e             state_q, state_d;
  logic [TAG_W-1:0]      miss_blk_q, miss_blk_d;
  logic [BLK_BITS-1:0]   fill_data_q, fill_data_d;

  logic [TAG_W-1:0]                      pc_blk;
  logic [WSEL_W-1:0]                     pc_wsel;
  logic [BLOCK_WORDS-1:0][WORD_BITS-1:0] dout_words;
  logic                                  unused_pc_lsbs;

  assign pc_blk         = pc[ADDR_W-1:OFF_W];
  assign pc_wsel        = pc[OFF_W-1:OFF_W-WSEL_W];
  assign dout_words     = cacheDout;  // word 0 sits in the LSBs
  assign unused_pc_lsbs = ^pc[OFF_W-WSEL_W-1:0];

`ifdef ICACHE_PREFETCH_EN
  logic                 pf_pending_q, pf_pending_d;
  logic [MEM_BLK_W-1:0] pf_addr_q, pf_addr_d;
  logic [MEM_BLK_W-1:0] pc_mblk;
  logic                 buf_wr_en, buf_match;
  logic [MEM_BLK_W-1:0] buf_wr_tag;
  logic [BLK_BITS-1:0]  buf_data;

  assign pc_mblk = pc_blk[MEM_BLK_W-1:0];

  icache_stream_buffer #(
    .TagW  (MEM_BLK_W),
    .DataW (BLK_BITS)
  ) u_stream_buffer (
    .clk_i        (clock),
    .rst_i        (reset),
    .wr_en_i      (buf_wr_en),
    .wr_tag_i     (buf_wr_tag),
    .wr_data_i    (imem_dout),
    .lookup_tag_i (pc_mblk),
    .match_o      (buf_match),
    .data_o       (buf_data)
  );
`endif

  always_comb begin
    state_d            = state_q;
    miss_blk_d         = miss_blk_q;
    fill_data_d        = fill_data_q;
    instr              = '0;
    icache_stall       = 1'b0;
    cacheRen           = 1'b0;
    cacheMemWen        = 1'b0;
    cacheBlockAddr     = '0;
    cacheDin           = '0;
    imem_ren           = 1'b0;
    imem_block_address = '0;
`ifdef ICACHE_PREFETCH_EN
    pf_pending_d = pf_pending_q;
    pf_addr_d    = pf_addr_q;
    buf_wr_en    = 1'b0;
    buf_wr_tag   = pf_addr_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef ICACHE_PREFETCH_EN
        // Background next-line read runs while the pipeline keeps hitting.
        if (pf_pending_q) begin
          imem_ren           = 1'b1;
          imem_block_address = pf_addr_q;
          if (imem_ready) begin
            buf_wr_en    = 1'b1;
            pf_pending_d = 1'b0;
          end
        end
`endif
        if (fetch_ren) begin
          cacheRen       = 1'b1;
          cacheBlockAddr = pc_blk;
          if (cacheHit) begin
            instr = dout_words[pc_wsel];
          end else begin
            icache_stall = 1'b1;
            miss_blk_d   = pc_blk;
`ifdef ICACHE_PREFETCH_EN
            if (pf_pending_q && imem_ready && (pf_addr_q == pc_mblk)) begin
              fill_data_d = imem_dout;
              state_d     = StFill;
            end else if (pf_pending_q && !imem_ready) begin
              state_d = StPfWait;
            end else if (buf_match) begin
              fill_data_d = buf_data;
              state_d     = StFill;
            end else begin
              state_d = StMissReq;
            end
`else
            state_d = StMissReq;
`endif
          end
        end
      end

      StMissReq: begin
        icache_stall       = 1'b1;
        imem_ren           = 1'b1;
        imem_block_address = miss_blk_q[MEM_BLK_W-1:0];
        if (imem_ready) begin
          fill_data_d = imem_dout;
          state_d     = StFill;
`ifdef ICACHE_PREFETCH_EN
          buf_wr_en  = 1'b1;
          buf_wr_tag = miss_blk_q[MEM_BLK_W-1:0];
`endif
        end
      end

      StFill: begin
        icache_stall   = 1'b1;
        cacheMemWen    = 1'b1;
        cacheBlockAddr = miss_blk_q;
        cacheDin       = fill_data_q;
        state_d        = StIdle;
`ifdef ICACHE_PREFETCH_EN
        pf_pending_d = 1'b1;
        pf_addr_d    = miss_blk_q[MEM_BLK_W-1:0] + MEM_BLK_W'(1);  // wraps at top of imem
`endif
      end

`ifdef ICACHE_PREFETCH_EN
      StPfWait: begin
        icache_stall       = 1'b1;
        imem_ren           = 1'b1;
        imem_block_address = pf_addr_q;
        if (imem_ready) begin
          buf_wr_en    = 1'b1;
          pf_pending_d = 1'b0;
          if (pf_addr_q == miss_blk_q[MEM_BLK_W-1:0]) begin
            fill_data_d = imem_dout;
            state_d     = StFill;
          end else begin
            state_d = StMissReq;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // Outputs stay quiet for the whole time reset is held.
    if (reset) begin
      instr              = '0;
      icache_stall       = 1'b0;
      cacheRen           = 1'b0;
      cacheMemWen        = 1'b0;
      cacheBlockAddr     = '0;
      cacheDin           = '0;
      imem_ren           = 1'b0;
      imem_block_address = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      miss_blk_q  <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_blk_q  <= miss_blk_d;
      fill_data_q <= fill_data_d;
    end
  end

`ifdef ICACHE_PREFETCH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pf_pending_q <= 1'b0;
      pf_addr_q    <= '0;
    end else begin
      pf_pending_q <= pf_pending_d;
      pf_addr_q    <= pf_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: bench for icache_controller in its default build.
// The bench provides an 8-set direct-mapped I_SRAM and a latency-programmable imem whose
// contents come from a fixed formula; expected behaviour is derived from the miss/fill
// timeline and from that formula.
module tb_icache_controller;

  logic          clock;
  logic          reset;
  logic          fetch_ren;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          icache_stall;
  logic          cacheRen;
  logic          cacheMemWen;
  logic [27:0]   cacheBlockAddr;
  logic [127:0]  cacheDin;
  logic          cacheHit;
  logic [127:0]  cacheDout;
  logic          imem_ren;
  logic [9:0]    imem_block_address;
  logic [127:0]  imem_dout;
  logic          imem_ready;

  icache_controller dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_ren          (fetch_ren),
    .pc                 (pc),
    .instr              (instr),
    .icache_stall       (icache_stall),
    .cacheRen           (cacheRen),
    .cacheMemWen        (cacheMemWen),
    .cacheBlockAddr     (cacheBlockAddr),
    .cacheDin           (cacheDin),
    .cacheHit           (cacheHit),
    .cacheDout          (cacheDout),
    .imem_ren           (imem_ren),
    .imem_block_address (imem_block_address),
    .imem_dout          (imem_dout),
    .imem_ready         (imem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // I_SRAM: 8 sets indexed by block[2:0], full block address kept as tag.
  logic         sv    [8];
  logic [27:0]  stag  [8];
  logic [127:0] sdata [8];

  assign cacheHit  = cacheRen && sv[cacheBlockAddr[2:0]] &&
                     (stag[cacheBlockAddr[2:0]] == cacheBlockAddr);
  assign cacheDout = sdata[cacheBlockAddr[2:0]];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the miss timeline.
  bit          m_active;
  bit          m_fill;
  logic [27:0] m_blk;
  int          mem_cnt;
  int          mem_lat;
  int          next_lat;
  bit          spur_en;
  int          stall_cnt;
  int          wen_cnt;

  function automatic logic [31:0] gold_word(input logic [27:0] b, input int unsigned w);
    logic [31:0] bb;
    bb = 32'(b);
    return (bb * 32'h9E37_79B1) ^ (32'(w) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] gold_block(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = gold_word(b, w);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic fr, input logic [31:0] p);
    logic [27:0]  pblk;
    logic [2:0]   idx;
    logic         hit;
    logic         wen;
    logic [27:0]  waddr;
    logic [127:0] wdata;
    @(negedge clock);
    fetch_ren  = fr;
    pc         = p;
    imem_ready = 1'b0;
    imem_dout  = '0;
    #1;
    if (imem_ren) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_dout  = gold_block(28'(imem_block_address));
      end
    end else if (spur_en && !m_active && ($urandom_range(0, 3) == 0)) begin
      imem_ready = 1'b1;  // stray pulse, must be ignored
      imem_dout  = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    if (icache_stall) stall_cnt++;
    if (cacheMemWen) wen_cnt++;
    wen   = cacheMemWen;
    waddr = cacheBlockAddr;
    wdata = cacheDin;
    pblk  = p[31:4];
    idx   = pblk[2:0];
    if (!m_active) begin
      if (fr) begin
        hit = sv[idx] && (stag[idx] == pblk);
        chk("lookup_ren", 128'(cacheRen), 128'(1'b1));
        chk("lookup_addr", 128'(cacheBlockAddr), 128'(pblk));
        chk("lookup_stall", 128'(icache_stall), 128'(!hit));
        chk("lookup_imem_ren", 128'(imem_ren), 128'(1'b0));
        chk("lookup_wen", 128'(cacheMemWen), 128'(1'b0));
        if (hit) chk("hit_instr", 128'(instr), 128'(gold_word(pblk, 32'(p[3:2]))));
        else begin
          m_active = 1'b1;
          m_fill   = 1'b0;
          m_blk    = pblk;
          mem_cnt  = 0;
          mem_lat  = next_lat;
        end
      end else begin
        chk("idle_ren", 128'(cacheRen), 128'(1'b0));
        chk("idle_stall", 128'(icache_stall), 128'(1'b0));
        chk("idle_instr", 128'(instr), 128'(0));
        chk("idle_imem_ren", 128'(imem_ren), 128'(1'b0));
        chk("idle_wen", 128'(cacheMemWen), 128'(1'b0));
      end
    end else if (!m_fill) begin
      chk("req_imem_ren", 128'(imem_ren), 128'(1'b1));
      chk("req_blk_addr", 128'(imem_block_address), 128'(m_blk[9:0]));
      chk("req_stall", 128'(icache_stall), 128'(1'b1));
      chk("req_wen", 128'(cacheMemWen), 128'(1'b0));
      if (imem_ready) m_fill = 1'b1;
    end else begin
      chk("fill_wen", 128'(cacheMemWen), 128'(1'b1));
      chk("fill_addr", 128'(cacheBlockAddr), 128'(m_blk));
      chk("fill_din", cacheDin, gold_block(m_blk));
      chk("fill_stall", 128'(icache_stall), 128'(1'b1));
      chk("fill_imem_ren", 128'(imem_ren), 128'(1'b0));
      m_active = 1'b0;
    end
    @(posedge clock);
    if (wen) begin
      sv[waddr[2:0]]    = 1'b1;
      stag[waddr[2:0]]  = waddr;
      sdata[waddr[2:0]] = wdata;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      sv[i]    = 1'b0;
      stag[i]  = '0;
      sdata[i] = '0;
    end
    m_active   = 1'b0;
    m_fill     = 1'b0;
    m_blk      = '0;
    mem_cnt    = 0;
    mem_lat    = 1;
    next_lat   = 1;
    spur_en    = 1'b0;
    stall_cnt  = 0;
    wen_cnt    = 0;
    reset      = 1'b1;
    fetch_ren  = 1'b1;
    pc         = 32'h40;
    imem_ready = 1'b0;
    imem_dout  = '0;

    // Outputs held at zero during reset even with a pending fetch.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", 128'(icache_stall), 128'(1'b0));
    chk("rst_ren", 128'(cacheRen), 128'(1'b0));
    chk("rst_imem_ren", 128'(imem_ren), 128'(1'b0));
    chk("rst_wen", 128'(cacheMemWen), 128'(1'b0));
    fetch_ren = 1'b0;
    reset     = 1'b0;

    // Reset asserted in the middle of a memory wait.
    next_lat = 20;
    step(1'b1, 32'h200);
    step(1'b1, 32'h200);
    step(1'b1, 32'h200);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_imem_ren", 128'(imem_ren), 128'(1'b0));
    chk("rst_mid_stall", 128'(icache_stall), 128'(1'b0));
    @(posedge clock);
    #1;
    chk("rst_edge_imem_ren", 128'(imem_ren), 128'(1'b0));
    chk("rst_edge_stall", 128'(icache_stall), 128'(1'b0));
    @(negedge clock);
    fetch_ren  = 1'b0;
    imem_ready = 1'b0;
    reset      = 1'b0;
    m_active   = 1'b0;
    m_fill     = 1'b0;
    mem_cnt    = 0;
    step(1'b0, 32'h0);

    // Cold fetch at 0x40, memory latency 5.
    next_lat  = 5;
    stall_cnt = 0;
    wen_cnt   = 0;
    step(1'b1, 32'h40);
    for (int i = 0; i < 40 && m_active; i++) step(1'b1, 32'h40);
    chk("cold_done", 128'(m_active), 128'(1'b0));
    step(1'b1, 32'h40);
    chk("cold_stall_cycles", 128'(stall_cnt), 128'(7));
    chk("cold_fill_pulses", 128'(wen_cnt), 128'(1));

    // Warm fetches from the same block.
    stall_cnt = 0;
    step(1'b1, 32'h44);
    step(1'b1, 32'h48);
    step(1'b1, 32'h4C);
    chk("warm_stall_cycles", 128'(stall_cnt), 128'(0));

    // Redirect during a miss: block 0x8 fills first, then 0x10 misses.
    next_lat = 4;
    wen_cnt  = 0;
    step(1'b1, 32'h80);
    for (int i = 0; i < 40 && m_active; i++) step(1'b1, 32'h100);
    step(1'b1, 32'h100);
    for (int i = 0; i < 40 && m_active; i++) step(1'b1, 32'h100);
    chk("redirect_done", 128'(m_active), 128'(1'b0));
    stall_cnt = 0;
    step(1'b1, 32'h100);
    chk("redirect_fills", 128'(wen_cnt), 128'(2));
    chk("redirect_replay_stall", 128'(stall_cnt), 128'(0));

    // Random traffic with redirects, idle cycles and stray imem_ready pulses.
    spur_en = 1'b1;
    begin
      logic [31:0] cur_pc;
      logic        cur_fr;
      cur_pc = 32'h40;
      for (int i = 0; i < 1500; i++) begin
        next_lat = $urandom_range(1, 6);
        cur_fr   = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 1) == 0)
          cur_pc = (32'($urandom_range(0, 31)) << 4) | (32'($urandom_range(0, 3)) << 2);
        step(cur_fr, cur_pc);
      end
    end
    spur_en = 1'b0;
    for (int i = 0; i < 40 && m_active; i++) step(1'b0, 32'h0);
    chk("random_drained", 128'(m_active), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
